// File: rtl/prog_ring_counter.sv
// Programmable ring / Johnson / bounce counter with prescaled stepping,
// parallel load and illegal-pattern self-correction.
//
// Ports:
//   Clock, Reset      rising-edge clock, synchronous active-high reset
//   en                count enable (0 holds pattern and tick counter)
//   mode              00 ring, 01 Johnson, 10 bounce, 11 hold
//   dir               0 shift toward MSB, 1 toward LSB (ignored in bounce)
//   prescale          step every prescale+1 enabled cycles
//   load, load_val    parallel load strobe and pattern
//   err_clr           clears the sticky err flag
//   Count_out         registered pattern
//   wrap              one-cycle pulse when a legal step lands on home
//   err               sticky flag: an illegal pattern was corrected
//   io_oeb            GPIO output enables, tied to all-outputs
module prog_ring_counter #(
   parameter int               WIDTH      = 4,
   parameter logic [WIDTH-1:0] INIT       = WIDTH'(1),
   parameter int               PRESCALE_W = 8
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  en,
   input  logic [1:0]            mode,
   input  logic                  dir,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  load,
   input  logic [WIDTH-1:0]      load_val,
   input  logic                  err_clr,
   output logic [WIDTH-1:0]      Count_out,
   output logic                  wrap,
   output logic                  err,
   output logic [WIDTH-1:0]      io_oeb
);

   localparam logic [WIDTH-1:0] HOME_J = '0;
   localparam logic [WIDTH-1:0] HOME_B = WIDTH'(1);

   logic [WIDTH-1:0]      cnt_q, cnt_d;
   logic [PRESCALE_W-1:0] tick_q, tick_d;
   logic                  bdir_q, bdir_d;
   logic                  wrap_q, wrap_d;
   logic                  err_q, err_d;

   logic                  step;
   logic                  legal;
   logic                  nbdir;
   logic [WIDTH-1:0]      nxt;
   logic [WIDTH-1:0]      home;
   logic [WIDTH-2:0]      trans;

   assign step  = en && (mode != 2'b11) && (tick_q == prescale);
   // Johnson patterns have at most one boundary between adjacent bits.
   assign trans = cnt_q[WIDTH-1:1] ^ cnt_q[WIDTH-2:0];

   always_comb begin
      nxt   = cnt_q;
      legal = 1'b1;
      home  = INIT;
      nbdir = bdir_q;
      case (mode)
         2'b00: begin
            home  = INIT;
            legal = $onehot(cnt_q);
            nxt   = dir ? {cnt_q[0], cnt_q[WIDTH-1:1]}
                        : {cnt_q[WIDTH-2:0], cnt_q[WIDTH-1]};
         end
         2'b01: begin
            home  = HOME_J;
            legal = ($countones(trans) <= 1);
            nxt   = dir ? {~cnt_q[0], cnt_q[WIDTH-1:1]}
                        : {cnt_q[WIDTH-2:0], ~cnt_q[WIDTH-1]};
         end
         2'b10: begin
            home  = HOME_B;
            legal = $onehot(cnt_q);
            // The reversing step also moves, inward.
            if (!bdir_q) begin
               if (cnt_q[WIDTH-1]) begin
                  nbdir = 1'b1;
                  nxt   = cnt_q >> 1;
               end else begin
                  nxt   = cnt_q << 1;
               end
            end else begin
               if (cnt_q[0]) begin
                  nbdir = 1'b0;
                  nxt   = cnt_q << 1;
               end else begin
                  nxt   = cnt_q >> 1;
               end
            end
         end
         default: begin
            nxt   = cnt_q;
            legal = 1'b1;
            home  = INIT;
         end
      endcase
   end

   always_comb begin
      cnt_d  = cnt_q;
      tick_d = tick_q;
      bdir_d = bdir_q;
      wrap_d = 1'b0;
      err_d  = err_q;
      if (err_clr) err_d = 1'b0;
      if (load) begin
         cnt_d  = load_val;
         tick_d = '0;
         bdir_d = 1'b0;
      end else if (step) begin
         tick_d = '0;
         if (!legal) begin
            // Correction wins over a simultaneous err_clr.
            cnt_d  = home;
            err_d  = 1'b1;
            bdir_d = 1'b0;
         end else begin
            cnt_d  = nxt;
            bdir_d = nbdir;
            wrap_d = (nxt == home);
         end
      end else if (mode == 2'b11) begin
         tick_d = '0;
      end else if (en) begin
         tick_d = tick_q + PRESCALE_W'(1);
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         cnt_q  <= INIT;
         tick_q <= '0;
         bdir_q <= 1'b0;
         wrap_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
         bdir_q <= bdir_d;
         wrap_q <= wrap_d;
         err_q  <= err_d;
      end
   end

   assign Count_out = cnt_q;
   assign wrap      = wrap_q;
   assign err       = err_q;
   assign io_oeb    = '0;

endmodule

// File: tb/tb_prog_ring_counter.sv
// Directed self-checking bench for prog_ring_counter
// (WIDTH=4, INIT=0001, PRESCALE_W=8).
module tb_prog_ring_counter;

   logic       Clock = 1'b0;
   logic       Reset;
   logic       en;
   logic [1:0] mode;
   logic       dir;
   logic [7:0] prescale;
   logic       load;
   logic [3:0] load_val;
   logic       err_clr;
   logic [3:0] Count_out;
   logic       wrap;
   logic       err;
   logic [3:0] io_oeb;

   int errors = 0;
   int checks = 0;

   prog_ring_counter #(
      .WIDTH(4), .INIT(4'b0001), .PRESCALE_W(8)
   ) dut (
      .Clock(Clock), .Reset(Reset), .en(en), .mode(mode), .dir(dir),
      .prescale(prescale), .load(load), .load_val(load_val),
      .err_clr(err_clr), .Count_out(Count_out), .wrap(wrap),
      .err(err), .io_oeb(io_oeb)
   );

   always #5 Clock = ~Clock;

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "simulation time limit");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic edge_chk(input string tag, input logic [3:0] c,
                           input logic w, input logic e);
      @(posedge Clock);
      #1;
      chk({tag, ".cnt"}, 32'(Count_out), 32'(c));
      chk({tag, ".wrap"}, 32'(wrap), 32'(w));
      chk({tag, ".err"}, 32'(err), 32'(e));
   endtask

   task automatic edge_only;
      @(posedge Clock);
      #1;
   endtask

   task automatic do_reset;
      Reset = 1'b1;
      edge_only();
      Reset = 1'b0;
   endtask

   initial begin
      Reset = 1'b1; en = 1'b0; mode = 2'b00; dir = 1'b0;
      prescale = 8'd0; load = 1'b0; load_val = 4'b0; err_clr = 1'b0;
      edge_only();
      edge_chk("rst", 4'b0001, 1'b0, 1'b0);
      chk("rst.oeb", 32'(io_oeb), 32'h0);
      Reset = 1'b0;

      // T1 ring
      en = 1'b1;
      edge_chk("t1a", 4'b0010, 1'b0, 1'b0);
      edge_chk("t1b", 4'b0100, 1'b0, 1'b0);
      edge_chk("t1c", 4'b1000, 1'b0, 1'b0);
      edge_chk("t1d", 4'b0001, 1'b1, 1'b0);
      dir = 1'b1;
      edge_chk("t1e", 4'b1000, 1'b0, 1'b0);

      // T2 Johnson
      dir = 1'b0; mode = 2'b01;
      do_reset();
      chk("t2.rst", 32'(Count_out), 32'h1);
      edge_chk("t2a", 4'b0011, 1'b0, 1'b0);
      edge_chk("t2b", 4'b0111, 1'b0, 1'b0);
      edge_chk("t2c", 4'b1111, 1'b0, 1'b0);
      edge_chk("t2d", 4'b1110, 1'b0, 1'b0);
      edge_chk("t2e", 4'b1100, 1'b0, 1'b0);
      edge_chk("t2f", 4'b1000, 1'b0, 1'b0);
      edge_chk("t2g", 4'b0000, 1'b1, 1'b0);
      edge_chk("t2h", 4'b0001, 1'b0, 1'b0);

      // T3 prescale=2, en gap of two cycles
      mode = 2'b00; prescale = 8'd2;
      do_reset();
      edge_chk("t3a", 4'b0001, 1'b0, 1'b0);
      edge_chk("t3b", 4'b0001, 1'b0, 1'b0);
      edge_chk("t3c", 4'b0010, 1'b0, 1'b0);
      edge_chk("t3d", 4'b0010, 1'b0, 1'b0);
      en = 1'b0;
      edge_chk("t3e", 4'b0010, 1'b0, 1'b0);
      edge_chk("t3f", 4'b0010, 1'b0, 1'b0);
      en = 1'b1;
      edge_chk("t3g", 4'b0010, 1'b0, 1'b0);
      edge_chk("t3h", 4'b0100, 1'b0, 1'b0);

      // T4 illegal load, correction, sticky err, err_clr
      prescale = 8'd0; en = 1'b0;
      do_reset();
      load = 1'b1; load_val = 4'b0110;
      edge_chk("t4ld", 4'b0110, 1'b0, 1'b0);
      load = 1'b0; en = 1'b1;
      edge_chk("t4fix", 4'b0001, 1'b0, 1'b1);
      en = 1'b0;
      edge_chk("t4stk", 4'b0001, 1'b0, 1'b1);
      err_clr = 1'b1;
      edge_chk("t4clr", 4'b0001, 1'b0, 1'b0);
      err_clr = 1'b0; load = 1'b1;
      edge_chk("t4ld2", 4'b0110, 1'b0, 1'b0);
      load = 1'b0; en = 1'b1; err_clr = 1'b1;
      edge_chk("t4both", 4'b0001, 1'b0, 1'b1);
      err_clr = 1'b0;

      // T5 bounce
      mode = 2'b10;
      do_reset();
      edge_chk("t5a", 4'b0010, 1'b0, 1'b0);
      edge_chk("t5b", 4'b0100, 1'b0, 1'b0);
      edge_chk("t5c", 4'b1000, 1'b0, 1'b0);
      edge_chk("t5d", 4'b0100, 1'b0, 1'b0);
      edge_chk("t5e", 4'b0010, 1'b0, 1'b0);
      edge_chk("t5f", 4'b0001, 1'b1, 1'b0);
      edge_chk("t5g", 4'b0010, 1'b0, 1'b0);

      // T6 reset beats load with tick mid-count
      mode = 2'b00; prescale = 8'd3;
      do_reset();
      edge_only();
      edge_only();
      Reset = 1'b1; load = 1'b1; load_val = 4'b1010;
      edge_chk("t6rst", 4'b0001, 1'b0, 1'b0);
      Reset = 1'b0; load = 1'b0;
      edge_chk("t6a", 4'b0001, 1'b0, 1'b0);
      edge_chk("t6b", 4'b0001, 1'b0, 1'b0);
      edge_chk("t6c", 4'b0001, 1'b0, 1'b0);
      edge_chk("t6d", 4'b0010, 1'b0, 1'b0);

      // mode=11 freezes pattern and keeps tick at 0
      mode = 2'b11;
      edge_chk("h1", 4'b0010, 1'b0, 1'b0);
      edge_chk("h2", 4'b0010, 1'b0, 1'b0);
      edge_chk("h3", 4'b0010, 1'b0, 1'b0);
      edge_chk("h4", 4'b0010, 1'b0, 1'b0);
      edge_chk("h5", 4'b0010, 1'b0, 1'b0);
      mode = 2'b00;
      edge_chk("h6", 4'b0010, 1'b0, 1'b0);
      edge_chk("h7", 4'b0010, 1'b0, 1'b0);
      edge_chk("h8", 4'b0010, 1'b0, 1'b0);
      edge_chk("h9", 4'b0100, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
